cordic_vec_arbiter: RTL and testbench
=====================================

# cordic_vec_arbiter

Time-shares one vectoring CORDIC core (DATA_WIDTH-in, ANGLE_WIDTH angle-out, level-enabled, `op_vld` on completion) between NUM_REQ requesters such as per-unit theta processors. Round-robin grant with one transaction in flight: latch operands, drive the core until valid, return magnitude and angle to the granted requester. Sits between the theta/rotation controllers and the single CORDIC instance and owns the core's enable and reset.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, operand and magnitude width, signed
- ANGLE_WIDTH, 16, angle width, signed
- TIMEOUT_CYCLES, 64, watchdog limit; used only with CORDIC_ARB_TIMEOUT_EN
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant/accept strobe
- req_xin_flat  in  NUM_REQ*DATA_WIDTH  x operands, requester i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- req_yin_flat  in  NUM_REQ*DATA_WIDTH  y operands, same packing
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
- rsp_xout  out  DATA_WIDTH  shared result magnitude
- rsp_angle  out  ANGLE_WIDTH  shared result angle
- rsp_err  out  1  timeout abort flag, qualified by rsp_valid
- busy  out  1  high outside IDLE
- cordic_xin, cordic_yin  out  DATA_WIDTH  core operands
- cordic_en  out  1  core enable (vec_en and angle enable)
- cordic_nrst  out  1  core reset, active-low
- cordic_xout  in  DATA_WIDTH  core magnitude
- cordic_angle_out  in  ANGLE_WIDTH  core angle
- cordic_op_vld  in  1  core result valid

## Operation
- States: IDLE, BUSY, RESP; ABORT only with CORDIC_ARB_TIMEOUT_EN.
- IDLE: if any req_valid, grant g = first set bit searching upward from rr_ptr with wrap; req_ready[g]=1 combinationally that cycle; handshake = req_valid[g] & req_ready[g]; latch g, xin, yin; -> BUSY. No req_valid: stay, req_ready=0.
- BUSY: cordic_en=1, cordic_xin/yin = latched operands, held stable. On cordic_op_vld: capture cordic_xout/cordic_angle_out into rsp regs -> RESP.
- RESP: rsp_valid[g]=1 one cycle, rsp_err as set; rr_ptr <= (g+1) mod NUM_REQ; -> IDLE.
- Requester operands need only be valid on the handshake cycle; dropping req_valid before grant is legal and yields no grant.
- cordic_op_vld outside BUSY is ignored.
- cordic_nrst = ~reset, except low in ABORT.
- Reset values: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_xout 0, rsp_angle 0, rsp_err 0, busy 0, cordic_en 0, cordic_xin/yin 0, cordic_nrst 0 while reset high.
- Reset mid-transaction: abandon at once, no rsp_valid issued, state IDLE next cycle.
- rsp_xout/rsp_angle hold last value until next capture.

## Timing
- Handshake in cycle T; cordic_en high from T+1 through the cycle op_vld is sampled (T+L); rsp_valid at T+L+1; next grant earliest T+L+2.
- cordic_en low for at least one cycle (RESP) between transactions.
- Throughput: one op per L+2 cycles, L = core latency from enable to op_vld.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.

## Configuration
- CORDIC_ARB_TIMEOUT_EN defined: counter cleared on entry to BUSY, increments each BUSY cycle; reaching TIMEOUT_CYCLES without op_vld -> ABORT: cordic_en=0, cordic_nrst=0 for 2 cycles -> RESP with rsp_err=1, rsp_xout=0, rsp_angle=0. op_vld on the limit cycle wins (normal capture).
- Undefined: no counter, no ABORT, rsp_err tied 0, TIMEOUT_CYCLES unused; BUSY waits indefinitely.

## Structure
- cordic_arb_pkg: state encoding, ABORT_NRST_CYCLES=2, requester index width function (clog2 of NUM_REQ).
- Sub-module rr_priority_pick: combinational one-hot round-robin picker (req vector, rr_ptr -> grant one-hot + index). FSM, operand latches and watchdog stay in top.

## Test plan
- Single request: requester 2, x=1000, y=1000 -> req_ready[2] one cycle, cordic_en held, rsp_valid[2] one cycle after op_vld, rsp_angle ≈ 45° code from core model.
- All four requesting continuously after reset -> grant order 0,1,2,3,0; no starvation; exactly one rsp_valid bit per transaction.
- Back-to-back: requester 1 re-requests immediately -> cordic_en low exactly one cycle between transactions, operands change only in the new BUSY.
- Reset asserted mid-BUSY -> no rsp_valid, all outputs at reset values next cycle, cordic_nrst low during reset.
- Timeout build, core model never asserts op_vld, TIMEOUT_CYCLES=8 -> 8 BUSY cycles, cordic_nrst low 2 cycles, rsp_valid with rsp_err=1, rsp_xout=0.
- Spurious cordic_op_vld in IDLE -> rsp regs unchanged, no rsp_valid.

Source files
------------

// File: rtl/cordic_arb_pkg.sv
// cordic_arb_pkg
//   Shared definitions for the CORDIC vectoring-core arbiter: FSM state
//   encoding, abort reset-pulse length and the requester index width helper.
//   Optional feature macro: CORDIC_ARB_TIMEOUT_EN. ST_ABORT is only reached
//   when it is defined.
package cordic_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    // Number of cycles the core is held in reset after a watchdog abort.
    localparam int ABORT_NRST_CYCLES = 2;

    // Width of a requester index. A single requester still needs one bit.
    function automatic int req_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin picker. Searches req upward from ptr,
//   wrapping at N, and returns the first set bit.
//   Ports:
//     req   in  N   request vector
//     ptr   in  IW  search start index (must be < N)
//     grant out N   one-hot grant, zero when no request
//     idx   out IW  index of the granted bit
//     any   out 1   at least one request present
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!any) begin
                j = (int'(ptr) + off) % N;
                if (req[j]) begin
                    any      = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/cordic_vec_arbiter.sv
// cordic_vec_arbiter
//   Time-shares one vectoring CORDIC core between NUM_REQ requesters with a
//   round-robin grant and one transaction in flight. Operands are latched on
//   the grant handshake, the core is enabled until it reports op_vld, and the
//   magnitude/angle are returned with a one-cycle strobe to the granted
//   requester.
//   Optional feature macro: CORDIC_ARB_TIMEOUT_EN adds a watchdog that aborts
//   a stuck core after TIMEOUT_CYCLES busy cycles, pulses the core reset and
//   returns a zero result flagged with rsp_err.
//   Ports:
//     clk, reset                synchronous active-high reset
//     req_valid / req_ready     per-requester request, one-hot accept strobe
//     req_xin_flat/req_yin_flat packed operands, requester i at slice i
//     rsp_valid                 one-hot, one-cycle result strobe
//     rsp_xout, rsp_angle       shared result registers (hold until next capture)
//     rsp_err                   watchdog abort flag, qualified by rsp_valid
//     busy                      high outside IDLE
//     cordic_*                  drive/observe the shared core
module cordic_vec_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ANGLE_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_xin_flat,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_yin_flat,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_xout,
    output logic [ANGLE_WIDTH-1:0]        rsp_angle,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         cordic_xin,
    output logic [DATA_WIDTH-1:0]         cordic_yin,
    output logic                          cordic_en,
    output logic                          cordic_nrst,
    input  logic [DATA_WIDTH-1:0]         cordic_xout,
    input  logic [ANGLE_WIDTH-1:0]        cordic_angle_out,
    input  logic                          cordic_op_vld
);

    localparam int IW = req_idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("cordic_vec_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cordic_vec_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t             state, state_nx;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          g_idx;
    logic [DATA_WIDTH-1:0]  x_lat, y_lat;
    logic [DATA_WIDTH-1:0]  xin_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  yin_arr [NUM_REQ];
    logic [NUM_REQ-1:0]     pick_grant;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            xin_arr[i] = req_xin_flat[i*DATA_WIDTH +: DATA_WIDTH];
            yin_arr[i] = req_yin_flat[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The core sees the latched operands directly; they only change on a
    // handshake, so they are stable for the whole BUSY window.
    assign cordic_xin = x_lat;
    assign cordic_yin = y_lat;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic [1:0]    ab_cnt;
    logic          to_hit;
    logic          ab_done;

    // to_cnt counts completed BUSY cycles, so it reads TIMEOUT_CYCLES-1 in
    // the last permitted BUSY cycle.
    assign to_hit  = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign ab_done = (ab_cnt == 2'(ABORT_NRST_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            ab_cnt <= '0;
        end else begin
            to_cnt <= (state == ST_BUSY)  ? TW'(to_cnt + 1'b1) : '0;
            ab_cnt <= (state == ST_ABORT) ? 2'(ab_cnt + 1'b1)  : '0;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        req_ready   = '0;
        rsp_valid   = '0;
        cordic_en   = 1'b0;
        busy        = (state != ST_IDLE);
        cordic_nrst = ~reset;
        case (state)
            ST_IDLE: begin
                // Grant is combinational; a raised req_valid is accepted in
                // the same cycle it is seen.
                if (!reset) req_ready = pick_grant;
                if (pick_any) state_nx = ST_BUSY;
            end
            ST_BUSY: begin
                cordic_en = 1'b1;
                if (cordic_op_vld) state_nx = ST_RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
                else if (to_hit) state_nx = ST_ABORT;
`endif
            end
            ST_RESP: begin
                rsp_valid[g_idx] = 1'b1;
                state_nx         = ST_IDLE;
            end
`ifdef CORDIC_ARB_TIMEOUT_EN
            ST_ABORT: begin
                cordic_nrst = 1'b0;
                if (ab_done) state_nx = ST_RESP;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            g_idx     <= '0;
            x_lat     <= '0;
            y_lat     <= '0;
            rsp_xout  <= '0;
            rsp_angle <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        g_idx <= pick_idx;
                        x_lat <= xin_arr[pick_idx];
                        y_lat <= yin_arr[pick_idx];
                    end
                end
                ST_BUSY: begin
                    // op_vld on the watchdog limit cycle still wins.
                    if (cordic_op_vld) begin
                        rsp_xout  <= cordic_xout;
                        rsp_angle <= cordic_angle_out;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                    end
`ifdef CORDIC_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        rsp_xout  <= '0;
                        rsp_angle <= '0;
                        rsp_err   <= 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    rr_ptr <= (g_idx == IW'(NUM_REQ - 1)) ? '0 : IW'(g_idx + 1'b1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// tb_cordic_vec_arbiter
//   Self-checking bench: behavioural CORDIC core model (real-valued
//   magnitude/atan2 with programmable latency) plus a transaction-level
//   reference model of the arbiter (grant order, phase, expected results).
module tb_cordic_vec_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_xin_flat;
    logic [N*DW-1:0]   req_yin_flat;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_xout;
    logic [AW-1:0]     rsp_angle;
    logic              rsp_err;
    logic              busy;
    logic [DW-1:0]     cordic_xin, cordic_yin;
    logic              cordic_en, cordic_nrst;
    logic [DW-1:0]     cordic_xout;
    logic [AW-1:0]     cordic_angle_out;
    logic              cordic_op_vld;

    always #5 clk = ~clk;

    cordic_vec_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .ANGLE_WIDTH    (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_xin_flat     (req_xin_flat),
        .req_yin_flat     (req_yin_flat),
        .rsp_valid        (rsp_valid),
        .rsp_xout         (rsp_xout),
        .rsp_angle        (rsp_angle),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .cordic_xin       (cordic_xin),
        .cordic_yin       (cordic_yin),
        .cordic_en        (cordic_en),
        .cordic_nrst      (cordic_nrst),
        .cordic_xout      (cordic_xout),
        .cordic_angle_out (cordic_angle_out),
        .cordic_op_vld    (cordic_op_vld)
    );

    // ---------------- core model ----------------
    function automatic logic [DW-1:0] mag_f(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
        real rx, ry;
        rx = x;
        ry = y;
        return DW'($rtoi($sqrt(rx*rx + ry*ry)));
    endfunction

    // Angle in units of pi * 2^-(AW-1), rounded to nearest.
    function automatic logic [AW-1:0] ang_f(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
        real a;
        int  ai;
        a  = $atan2($itor(y), $itor(x)) / 3.14159265358979 * 32768.0;
        ai = $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5);
        return AW'(ai);
    endfunction

    int            lat = 3;
    bit            never_vld = 1'b0;
    bit            spur = 1'b0;
    int            cnt;
    logic [DW-1:0] junk_x = '0;
    logic [AW-1:0] junk_a = '0;

    always @(posedge clk) begin
        if (!cordic_nrst || !cordic_en) cnt <= 0;
        else                            cnt <= cnt + 1;
    end

    assign cordic_op_vld    = (cordic_en && !never_vld && cnt == lat - 1) || spur;
    assign cordic_xout      = cordic_en ? mag_f(cordic_xin, cordic_yin) : junk_x;
    assign cordic_angle_out = cordic_en ? ang_f(cordic_xin, cordic_yin) : junk_a;

    // Length of each cordic_en low run between two enabled periods.
    int gaps[$];
    bit seen_en;
    int lowrun;
    always @(posedge clk) begin
        if (reset) begin
            seen_en <= 1'b0;
            lowrun  <= 0;
        end else if (cordic_en) begin
            if (seen_en && lowrun > 0) gaps.push_back(lowrun);
            seen_en <= 1'b1;
            lowrun  <= 0;
        end else begin
            lowrun <= lowrun + 1;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int            ptr, ph, g, rsp_cnt;   // ph: 0 idle, 1 busy, 2 resp
    logic [DW-1:0] ex, ey, exp_x, last_x;
    logic [AW-1:0] exp_a, last_a;
    int            wt[N];
    int            gq[$];
    int            mode;                  // 0 random, 1 all hold, 2 req1 hold, 3 directed
    bit            force_spur;
    logic [N-1:0]  pend;
    logic [DW-1:0] opx[N], opy[N];

    task automatic model_reset();
        ptr = 0; ph = 0; g = 0;
        ex = '0; ey = '0; last_x = '0; last_a = '0;
        pend = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;
    endtask

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_xin_flat[i*DW +: DW] = opx[i];
            req_yin_flat[i*DW +: DW] = opy[i];
        end
    endtask

    // One clock: called at negedge, returns at next negedge.
    task automatic step();
        int pick, nph;
        case (mode)
            0: for (int i = 0; i < N; i++) begin
                   if (!pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b1;
                   else if (pend[i] && $urandom_range(0, 15) == 0) begin
                       pend[i] = 1'b0;
                       wt[i]   = 0;
                   end
               end
            1: pend = '1;
            2: pend[1] = 1'b1;
            default: ;
        endcase
        if (mode != 3)
            for (int i = 0; i < N; i++) begin
                opx[i] = DW'(int'($urandom_range(0, 60000)) - 30000);
                opy[i] = DW'(int'($urandom_range(0, 60000)) - 30000);
            end
        junk_x = DW'($urandom);
        junk_a = AW'($urandom);
        spur   = (ph == 0) && (force_spur || (mode == 0 && $urandom_range(0, 5) == 0));
        if (ph == 0) lat = $urandom_range(1, 5);
        drive();
        #1;
        pick = -1;
        if (ph == 0)
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr + k) % N;
                if (pick < 0 && pend[j]) pick = j;
            end
        nph = ph;
        chk("nrst", cordic_nrst, 1);
        chk("busy", busy, ph != 0);
        case (ph)
            0: begin
                chk("ready", req_ready, pick < 0 ? 0 : (64'd1 << pick));
                chk("en_idle", cordic_en, 0);
                chk("rsp_idle", rsp_valid, 0);
                chk("hold_x", rsp_xout, last_x);
                chk("hold_a", rsp_angle, last_a);
                chk("xin_hold", cordic_xin, ex);
                if (pick >= 0) begin
                    g  = pick;
                    ex = opx[pick];
                    ey = opy[pick];
                    chk("fair", wt[pick] <= N - 1, 1);
                    for (int i = 0; i < N; i++) if (pend[i] && i != pick) wt[i]++;
                    wt[pick] = 0;
                    gq.push_back(pick);
                    nph = 1;
                end
            end
            1: begin
                chk("ready_busy", req_ready, 0);
                chk("en_busy", cordic_en, 1);
                chk("xin", cordic_xin, ex);
                chk("yin", cordic_yin, ey);
                chk("rsp_busy", rsp_valid, 0);
                chk("hold_x", rsp_xout, last_x);
                if (cordic_op_vld) begin
                    exp_x = mag_f(ex, ey);
                    exp_a = ang_f(ex, ey);
                    nph   = 2;
                end
            end
            default: begin
                chk("rsp_valid", rsp_valid, 64'd1 << g);
                chk("rsp_xout", rsp_xout, exp_x);
                chk("rsp_angle", rsp_angle, exp_a);
                chk("rsp_err", rsp_err, 0);
                chk("en_resp", cordic_en, 0);
                chk("ready_resp", req_ready, 0);
                chk("xin_resp", cordic_xin, ex);
                last_x = exp_x;
                last_a = exp_a;
                ptr    = (g + 1) % N;
                rsp_cnt++;
                nph    = 0;
            end
        endcase
        @(posedge clk);
        if (ph == 0 && nph == 1) pend[g] = 1'b0;
        ph = nph;
        @(negedge clk);
    endtask

    task automatic do_reset();
        pend = '0;
        drive();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        gq.delete();
    endtask

    task automatic drain();
        mode = 3;
        pend = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;
        for (int c = 0; c < 30 && ph != 0; c++) step();
        chk("drain", ph, 0);
    endtask

    initial begin
        int base, exp_o[5];
        reset = 1'b1;
        mode = 3; force_spur = 0; rsp_cnt = 0;
        model_reset();
        for (int i = 0; i < N; i++) begin opx[i] = '0; opy[i] = '0; end
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", cordic_en, 0);
        chk("rst_nrst", cordic_nrst, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_xout", rsp_xout, 0);
        chk("rst_angle", rsp_angle, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_xin", cordic_xin, 0);
        chk("rst_yin", cordic_yin, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single request from requester 2, 45 degrees.
        opx[2] = 1000; opy[2] = 1000;
        pend = 4'b0100;
        base = rsp_cnt;
        for (int c = 0; c < 40 && rsp_cnt == base; c++) step();
        chk("t1_done", rsp_cnt, base + 1);
        chk("t1_grants", gq.size(), 1);
        chk("t1_gidx", gq[0], 2);
        chk("angle45", last_a, 16'd8192);
        chk("mag1414", last_x, 1414);

        // Spurious op_vld while idle must not touch the result registers.
        force_spur = 1;
        step();
        force_spur = 0;
        step();
        chk("spur_x", rsp_xout, last_x);

        // All four requesting continuously from reset.
        do_reset();
        mode = 1;
        for (int c = 0; c < 200 && gq.size() < 5; c++) step();
        chk("t2_cnt", gq.size() >= 5, 1);
        exp_o = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) chk("order", gq[k], exp_o[k]);
        drain();

        // Requester 1 back-to-back.
        mode = 2;
        gaps.delete();
        base = rsp_cnt;
        for (int c = 0; c < 100 && rsp_cnt < base + 3; c++) step();
        chk("t3_done", rsp_cnt, base + 3);
        chk("t3_gaps", gaps.size() >= 2, 1);
        // Low run covers RESP plus the following IDLE grant cycle.
        foreach (gaps[k]) chk("en_gap", gaps[k], 2);
        drain();

        // Reset in the middle of BUSY.
        never_vld = 1;
        pend = 4'b1000;
        for (int c = 0; c < 10 && ph != 1; c++) step();
        step();
        step();
        chk("t4_busy", ph, 1);
        pend = '0;
        drive();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_en", cordic_en, 0);
        chk("mrst_rsp", rsp_valid, 0);
        chk("mrst_nrst", cordic_nrst, 0);
        chk("mrst_xout", rsp_xout, 0);
        chk("mrst_xin", cordic_xin, 0);
        @(posedge clk);
        #1;
        chk("mrst_rsp2", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        never_vld = 0;
        model_reset();

`ifdef CORDIC_ARB_TIMEOUT_EN
        begin
            int en_n, nrst_n;
            bit done, hs;
            en_n = 0; nrst_n = 0; done = 0; hs = 0;
            never_vld = 1;
            opx[0] = 77; opy[0] = 5;
            pend = 4'b0001;
            drive();
            for (int c = 0; c < 40 && !done; c++) begin
                #1;
                if (req_ready[0]) hs = 1;
                if (cordic_en) en_n++;
                if (!cordic_nrst) nrst_n++;
                if (rsp_valid != 0) begin
                    done = 1;
                    chk("to_rv", rsp_valid, 1);
                    chk("to_err", rsp_err, 1);
                    chk("to_x", rsp_xout, 0);
                    chk("to_a", rsp_angle, 0);
                end
                @(negedge clk);
                if (hs) begin pend = '0; drive(); end
            end
            chk("to_done", done, 1);
            chk("to_en_cycles", en_n, TO);
            chk("to_nrst_cycles", nrst_n, 2);
            never_vld = 0;
        end
`endif

        // Randomized traffic.
        do_reset();
        mode = 0;
        base = rsp_cnt;
        for (int c = 0; c < 800; c++) step();
        chk("rand_progress", rsp_cnt > base + 20, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
